// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// The optional grant statistics are enabled with macro FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam int unsigned DROP_CNT_W = 16;

  // Index width for n items, never below one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req scanning upward from last+1 with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  win,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    logic        found;
    win   = '0;
    any   = |req;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters with bounded bursts.
// Define FIFO_ARB_STATS_EN to add per-requester grant counters on port grant_cnt.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BURST_LEN  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  output logic [id_w(N_REQ)-1:0]        grant_id,
  output logic [DROP_CNT_W-1:0]         drop_cnt
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]           grant_cnt
`endif
);

  localparam int unsigned ID_W = id_w(N_REQ);
  localparam int unsigned BC_W = id_w(BURST_LEN);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN - 1);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  last, pick_win, win;
  logic             pick_any, hold, acc, has_grant, wr_pend;
  logic [BC_W-1:0]  burst_cnt, burst_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req  (req_valid),
    .last (last),
    .win  (pick_win),
    .any  (pick_any)
  );

  // Burst hold only applies once someone has actually been granted; the reset value
  // of last is a scan origin, not a real previous winner.
  assign hold = has_grant && req_valid[last] && (burst_cnt < BURST_MAX);
  assign win  = hold ? last : pick_win;
  assign acc  = rst_n && pick_any && !full && !(fifo_wr_en && almostfull);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    burst_nxt = burst_cnt;
    if (acc) begin
      state_nxt      = WRITE;
      req_ready[win] = 1'b1;
      if (win == last) burst_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
      else             burst_nxt = '0;
    end else if (pick_any) begin
      state_nxt = STALL;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
      last         <= ID_W'(N_REQ - 1);
      burst_cnt    <= '0;
      has_grant    <= 1'b0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) begin
        fifo_data_in <= req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
        grant_id     <= win;
        last         <= win;
        burst_cnt    <= burst_nxt;
        has_grant    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_pend <= fifo_wr_en;
      if (wr_pend && !wr_ack && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected writes, a negedge monitor checks them.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_data_in;
  logic             full, almostfull, wr_ack;
  logic [1:0]       grant_id;
  logic [15:0]      drop_cnt;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  fifo_wr_arbiter #(
    .FIFO_WIDTH (W),
    .N_REQ      (N),
    .BURST_LEN  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .full         (full),
    .almostfull   (almostfull),
    .wr_ack       (wr_ack),
    .grant_id     (grant_id),
    .drop_cnt     (drop_cnt)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  tag    = 0;
  logic ack_en  = 1'b1;
  logic wr_hist = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple FIFO model for the acknowledge: ack the cycle after each write unless ack_en is low.
  initial forever begin
    @(negedge clk);
    wr_hist = fifo_wr_en;
  end
  initial forever begin
    @(posedge clk);
    #1;
    wr_ack = ack_en & wr_hist;
  end

  // Monitor: every presented write must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {46'd0, grant_id, fifo_data_in}, 64'hDEAD);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_grant_id", grant_id, e.id);
        chk("wr_data", fifo_data_in, e.data);
      end
    end
  end

  // Drive one cycle starting just after a posedge; check req_ready at the negedge.
  task automatic step(input logic [3:0] v, input logic [3:0] exp_ready, input int exp_win);
    logic [15:0] d;
    wr_t e;
    tag++;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      d = 16'(i * 16'h1000 + tag);
      req_data[i*W +: W] = d;
      if (i == exp_win) begin
        e.id   = 2'(i);
        e.data = d;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[9];
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    full = 1'b0; almostfull = 1'b0; wr_ack = 1'b0;
    #12;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a write.
    step(4'b0001, 4'b0001, -1);
    chk("mid_wr_en_before", fifo_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_data", fifo_data_in, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step(4'b0000, 4'b0000, -1);
    chk("mid_rst_drop_after", drop_cnt, 0);

    // All four requesting: bursts of two, round-robin.
    for (int c = 0; c < 9; c++) begin
      step(4'hF, 4'(1 << seq[c]), seq[c]);
`ifdef FIFO_ARB_STATS_EN
      if (c == 7)
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 2);
`endif
    end
    step(4'b0000, 4'b0000, -1);

    // Lone requester wins every cycle.
    repeat (5) step(4'b0100, 4'b0100, 2);
    step(4'b0000, 4'b0000, -1);

    // Full blocks everything.
    full = 1'b1;
    step(4'hF, 4'b0000, -1);
    chk("full_wr_en", fifo_wr_en, 0);
    chk("full_state", dut.state, STALL);
    full = 1'b0;
    step(4'b0000, 4'b0000, -1);
    chk("idle_state", dut.state, IDLE);

    // Almostfull only blocks while a write is pending.
    step(4'b0001, 4'b0001, 0);
    almostfull = 1'b1;
    step(4'b0001, 4'b0000, -1);
    chk("af_wr_en", fifo_wr_en, 0);
    step(4'b0001, 4'b0001, 0);
    almostfull = 1'b0;
    repeat (2) step(4'b0000, 4'b0000, -1);

    // Lost write counting and saturation.
    chk("drop_before", drop_cnt, 0);
    ack_en = 1'b0;
    step(4'b0001, 4'b0001, 0);
    repeat (3) step(4'b0000, 4'b0000, -1);
    chk("drop_one", drop_cnt, 1);
    ack_en = 1'b1;
    force dut.drop_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.drop_cnt;
    @(posedge clk); #1;
    chk("drop_preload", drop_cnt, 16'hFFFF);
    ack_en = 1'b0;
    step(4'b0001, 4'b0001, 0);
    repeat (3) step(4'b0000, 4'b0000, -1);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    ack_en = 1'b1;

    repeat (2) step(4'b0000, 4'b0000, -1);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
